// File: rtl/mario_vertical_physics.sv
// Vertical motion controller for Mario: signed velocity, divided gravity, terminal
// fall speed and tile-edge snapping. Define JUMP_CUT_EN for variable jump height.
module mario_vertical_physics #(
  parameter int GRID_ROWS         = 12,
  parameter int GRID_COLS         = 17,
  parameter int BLOCK_WIDTH       = 40,
  parameter int MARIO_WIDTH       = 42,
  parameter int START_Y           = 358,
  parameter int JUMP_VELOCITY     = 8,
  parameter int JUMP_CUT_VELOCITY = 3,
  parameter int GRAVITY_DIV       = 4,
  parameter int MAX_FALL_VELOCITY = 8
) (
  input  logic                                        movement_clock,
  input  logic                                        reset,
  input  logic                                        jump,
  input  logic [GRID_ROWS-1:0][GRID_COLS-1:0][7:0]    background,
  input  logic signed [31:0]                          mario_x,
  output logic signed [31:0]                          mario_y,
  output logic signed [31:0]                          vel_y,
  output logic                                        on_ground
);

  localparam logic [7:0] BDR = 8'd0;
  localparam logic [7:0] SKY = 8'd1;
  localparam logic [7:0] BLK = 8'd2;
  localparam logic [7:0] GND = 8'd3;

  localparam int ROW_W = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int CNT_W = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;

`ifdef JUMP_CUT_EN
  localparam bit CUT_EN = 1'b1;
`else
  localparam bit CUT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_RESET,
    S_GROUNDED,
    S_RISING,
    S_FALLING
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   grav_cnt;
  logic               jump_q;

  logic               jump_edge;
  logic               grav_wrap;
  logic signed [31:0] col_l;
  logic signed [31:0] col_r;
  logic signed [31:0] sup_row;
  logic               sup_hit;
  logic signed [31:0] rise_vel;
  logic signed [31:0] rise_cand;
  logic signed [31:0] top_row;
  logic               top_hit;
  logic signed [31:0] fall_cand;
  logic signed [31:0] bot_row;
  logic               bot_hit;

  // Anything outside the grid behaves as border, which is solid.
  function automatic logic is_solid(input logic signed [31:0] row,
                                    input logic signed [31:0] col);
    logic [7:0] code;
    if (row < 0 || row >= GRID_ROWS || col < 0 || col >= GRID_COLS) return 1'b1;
    code = background[row[ROW_W-1:0]][col[COL_W-1:0]];
    return (code == BLK) || (code == GND) || (code == BDR);
  endfunction

  assign jump_edge = jump & ~jump_q;
  assign grav_wrap = (grav_cnt == CNT_W'(GRAVITY_DIV - 1));

  always_comb begin
    // NOTE: every signal gets a default first so no latch can be inferred.
    col_l     = (mario_x + 1) / BLOCK_WIDTH;
    col_r     = (mario_x + MARIO_WIDTH - 2) / BLOCK_WIDTH;
    sup_row   = (mario_y + MARIO_WIDTH) / BLOCK_WIDTH;
    sup_hit   = is_solid(sup_row, col_l) || is_solid(sup_row, col_r);

    rise_vel  = vel_y;
    if (CUT_EN && !jump && (vel_y < -JUMP_CUT_VELOCITY)) rise_vel = -JUMP_CUT_VELOCITY;
    rise_cand = mario_y + rise_vel;
    // Truncating division would map small negative y onto row 0; above the grid is row -1.
    top_row   = (rise_cand < 0) ? -32'sd1 : rise_cand / BLOCK_WIDTH;
    top_hit   = is_solid(top_row, col_l) || is_solid(top_row, col_r);

    fall_cand = mario_y + vel_y;
    bot_row   = (fall_cand + MARIO_WIDTH - 1) / BLOCK_WIDTH;
    bot_hit   = is_solid(bot_row, col_l) || is_solid(bot_row, col_r);
  end

  always_ff @(posedge movement_clock or negedge reset) begin
    if (!reset) begin
      state     <= S_RESET;
      mario_y   <= START_Y;
      vel_y     <= '0;
      on_ground <= 1'b0;
      grav_cnt  <= '0;
      jump_q    <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every branch sees pre-edge values.
      jump_q <= jump;
      case (state)
        S_RESET: begin
          state     <= S_GROUNDED;
          on_ground <= 1'b1;
        end

        S_GROUNDED: begin
          if (!sup_hit) begin
            state     <= S_FALLING;
            vel_y     <= '0;
            grav_cnt  <= '0;
            on_ground <= 1'b0;
          end else if (jump_edge) begin
            state     <= S_RISING;
            vel_y     <= -JUMP_VELOCITY;
            grav_cnt  <= '0;
            on_ground <= 1'b0;
          end
        end

        S_RISING: begin
          if (top_hit) begin
            mario_y  <= (top_row + 1) * BLOCK_WIDTH;
            vel_y    <= '0;
            grav_cnt <= '0;
            state    <= S_FALLING;
          end else begin
            mario_y <= rise_cand;
            if (grav_wrap) begin
              grav_cnt <= '0;
              vel_y    <= rise_vel + 1;
              if (rise_vel + 1 >= 0) state <= S_FALLING;
            end else begin
              grav_cnt <= grav_cnt + CNT_W'(1);
              vel_y    <= rise_vel;
            end
          end
        end

        S_FALLING: begin
          if (bot_hit) begin
            mario_y   <= bot_row * BLOCK_WIDTH - MARIO_WIDTH;
            vel_y     <= '0;
            grav_cnt  <= '0;
            state     <= S_GROUNDED;
            on_ground <= 1'b1;
          end else begin
            mario_y <= fall_cand;
            if (grav_wrap) begin
              grav_cnt <= '0;
              if (vel_y < MAX_FALL_VELOCITY) vel_y <= vel_y + 1;
              else                           vel_y <= MAX_FALL_VELOCITY;
            end else begin
              grav_cnt <= grav_cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state     <= S_RESET;
          on_ground <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mario_vertical_physics.sv
// Scoreboard bench for mario_vertical_physics: stimulus queues per-tick expectations,
// a monitor pops and compares them after each clock edge or asynchronous reset.
module tb_mario_vertical_physics;

  localparam int ROWS = 12;
  localparam int COLS = 17;
  localparam logic [7:0] SKY = 8'd1;
  localparam logic [7:0] BLK = 8'd2;
  localparam logic [7:0] GND = 8'd3;

`ifdef JUMP_CUT_EN
  localparam bit HOLD_JUMP = 1'b1;
`else
  localparam bit HOLD_JUMP = 1'b0;
`endif

  logic                             movement_clock = 1'b0;
  logic                             reset = 1'b0;
  logic                             jump = 1'b0;
  logic [ROWS-1:0][COLS-1:0][7:0]   background;
  logic signed [31:0]               mario_x = 32'sd100;
  logic signed [31:0]               mario_y;
  logic signed [31:0]               vel_y;
  logic                             on_ground;

  typedef struct {
    string name;
    int    y;
    int    vel;
    bit    chk_vel;
    bit    grd;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   y_end;

  mario_vertical_physics dut (
    .movement_clock (movement_clock),
    .reset          (reset),
    .jump           (jump),
    .background     (background),
    .mario_x        (mario_x),
    .mario_y        (mario_y),
    .vel_y          (vel_y),
    .on_ground      (on_ground)
  );

  always #5 movement_clock = ~movement_clock;

  task automatic check(input string name, input logic signed [31:0] actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge movement_clock or negedge reset);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, "_y"}, mario_y, e.y);
        if (e.chk_vel) check({e.name, "_vel"}, vel_y, e.vel);
        check({e.name, "_grd"}, 32'(on_ground), int'(e.grd));
      end
    end
  end

  task automatic push(input string nm, input int y, input int v, input bit cv, input bit g);
    exp_t e;
    e.name = nm; e.y = y; e.vel = v; e.chk_vel = cv; e.grd = g;
    sb.push_back(e);
  endtask

  task automatic step(input string nm, input int y, input int v, input bit cv, input bit g);
    push(nm, y, v, cv, g);
    @(negedge movement_clock);
  endtask

  task automatic set_grid();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        background[r][c] = (r == 10) ? GND : SKY;
  endtask

  task automatic do_reset(input string nm);
    jump = 1'b0;
    set_grid();
    push({nm, "_rst"}, 358, 0, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge movement_clock);
    reset = 1'b1;
    step({nm, "_rel"}, 358, 0, 1'b1, 1'b1);
  endtask

  task automatic rise_expect(input string nm, input int y0, input int ceil_y, output int yo);
    int y, v, c, cand;
    y = y0; v = -8; c = 0;
    for (int i = 0; i < 64; i++) begin
      cand = y + v;
      if (cand < ceil_y) begin
        y = ceil_y; v = 0;
        step($sformatf("%s_bump%0d", nm, i), y, v, 1'b1, 1'b0);
        break;
      end
      y = cand;
      if (c == 3) begin c = 0; v++; end else c++;
      step($sformatf("%s_%0d", nm, i), y, v, 1'b1, 1'b0);
      if (v == 0) break;
    end
    yo = y;
  endtask

  task automatic fall_expect(input string nm, input int y0, input int floor_top);
    int y, v, c, cand;
    y = y0; v = 0; c = 0;
    for (int i = 0; i < 100; i++) begin
      cand = y + v;
      if (cand + 42 > floor_top) begin
        step($sformatf("%s_land%0d", nm, i), floor_top - 42, 0, 1'b1, 1'b1);
        break;
      end
      y = cand;
      if (c == 3) begin c = 0; if (v < 8) v++; end else c++;
      step($sformatf("%s_%0d", nm, i), y, v, 1'b1, 1'b0);
    end
  endtask

  task automatic wait_ground(input string nm, input int max_ticks);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_ticks; i++) begin
      if (on_ground === 1'b1) begin seen = 1'b1; break; end
      @(negedge movement_clock);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: on_ground not seen within %0d ticks", nm, max_ticks);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    // Reset state and first grounded tick.
    do_reset("t1");
    step("t1_hold", 358, 0, 1'b1, 1'b1);

`ifndef JUMP_CUT_EN
    // One-tick jump pulse: full-height arc, peak 214, landing at 358.
    jump = 1'b1;
    step("t2_edge", 358, -8, 1'b1, 1'b0);
    jump = 1'b0;
    rise_expect("t2_rise", 358, 0, y_end);
    check("t2_peak", y_end, 214);
    fall_expect("t2_fall", 214, 400);
    step("t2_rest", 358, 0, 1'b1, 1'b1);
`else
    // Early release clamps the take-off speed to 3: peak 334.
    begin
      int ys[12] = '{355, 352, 349, 346, 344, 342, 340, 338, 337, 336, 335, 334};
      int vs[12] = '{-3, -3, -3, -2, -2, -2, -2, -1, -1, -1, -1, 0};
      jump = 1'b1;
      step("t6_edge", 358, -8, 1'b1, 1'b0);
      jump = 1'b0;
      for (int i = 0; i < 12; i++) step($sformatf("t6_cut%0d", i), ys[i], vs[i], 1'b1, 1'b0);
      wait_ground("t6", 60);
      step("t6_rest", 358, 0, 1'b1, 1'b1);
    end
`endif

    // Head bump on BLK at row 5: snap to 240, then fall back; held jump never re-triggers.
    do_reset("t3");
    background[5][2] = BLK;
    background[5][3] = BLK;
    jump = 1'b1;
    step("t3_edge", 358, -8, 1'b1, 1'b0);
    rise_expect("t3_rise", 358, 240, y_end);
    check("t3_snap", y_end, 240);
    step("t3_fall_start", 240, 0, 1'b0, 1'b0);
    wait_ground("t3", 80);
    for (int i = 0; i < 3; i++) step($sformatf("t3_held%0d", i), 358, 0, 1'b1, 1'b1);
    jump = 1'b0;

    // Partial support keeps Mario grounded; removing both tiles drops him to the border row.
    do_reset("t4a");
    background[10][2] = SKY;
    step("t4a_half_l", 358, 0, 1'b1, 1'b1);
    background[10][2] = GND;
    background[10][3] = SKY;
    step("t4a_half_r", 358, 0, 1'b1, 1'b1);
    background[10][2] = SKY;
    step("t4a_leave", 358, 0, 1'b1, 1'b0);
    fall_expect("t4a_fall", 358, 480);
    step("t4a_rest", 438, 0, 1'b1, 1'b1);

    // Jump, open a hole while airborne: long fall saturates at 8 and lands on the border.
    do_reset("t4b");
    jump = 1'b1;
    step("t4b_edge", 358, -8, 1'b1, 1'b0);
    if (!HOLD_JUMP) jump = 1'b0;
    background[10][2] = SKY;
    background[10][3] = SKY;
    rise_expect("t4b_rise", 358, 0, y_end);
    fall_expect("t4b_fall", 214, 480);
    step("t4b_rest", 438, 0, 1'b1, 1'b1);
    jump = 1'b0;

    // Asynchronous reset mid-rise takes effect without a clock edge.
    do_reset("t5");
    jump = 1'b1;
    step("t5_edge", 358, -8, 1'b1, 1'b0);
    repeat (9) @(negedge movement_clock);
    @(posedge movement_clock);
    #2;
    push("t5_async", 358, 0, 1'b1, 1'b0);
    reset = 1'b0;
    @(negedge movement_clock);
    reset = 1'b1;
    jump = 1'b0;
    step("t5_exit", 358, 0, 1'b1, 1'b1);

    repeat (2) @(negedge movement_clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
